msgdma_stream_source: RTL and testbench

Buffered Avalon-ST source that feeds an mSGDMA streaming sink (st_sink_*) from a sampled data port such as DAC80004 readback or stage position words. Captured words are queued in a parametrised synchronous FIFO and issued with a full valid/ready handshake, ready latency 0. Packet framing (startofpacket/endofpacket) is generated from a programmable packet length. Overflow is detected and counted.

---
 rtl/msgdma_pkg.sv | 20 ++
 rtl/msgdma_sync_fifo.sv | 66 ++++++
 rtl/msgdma_stream_source.sv | 109 ++++++++++
 tb/tb_msgdma_stream_source.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/msgdma_pkg.sv
// Shared constants, types and helpers for the mSGDMA stream source.
package msgdma_pkg;

  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefDepth  = 16;
  localparam int unsigned DefPktLen = 8;
  localparam int unsigned DefOvfW   = 16;

  // Packet framing flags presented alongside each outgoing word.
  typedef struct packed {
    logic sop;
    logic eop;
  } frame_flags_t;

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int unsigned clog2_plus1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/msgdma_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is visible whenever the FIFO is
// non-empty; occupancy is tracked explicitly so pointers need no wrap bit.
module msgdma_sync_fifo
  import msgdma_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_push,
  input  logic                            i_pop,
  input  logic                            i_flush,
  input  logic [DATA_W-1:0]               i_data,
  output logic [DATA_W-1:0]               o_data,
  output logic                            o_empty,
  output logic                            o_full,
  output logic [clog2_plus1(DEPTH)-1:0]   o_level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = clog2_plus1(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [LvlW-1:0]   r_level;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LvlW'(DEPTH));
  assign o_level = r_level;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Empty FIFO reads as zero so the data output is defined out of reset.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy update; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop) begin
        r_level <= r_level + LvlW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LvlW'(1);
      end
    end
  end

  // Word storage; contents need no reset because an empty FIFO masks the head.
  always_ff @(posedge clk) begin
    if (reset_n && !i_flush && w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/msgdma_stream_source.sv
// Avalon-ST source feeding an mSGDMA streaming sink. Captures sampled words into
// a show-ahead FIFO, frames them into fixed-length packets and counts drops.
module msgdma_stream_source
  import msgdma_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned DEPTH     = DefDepth,
  parameter int unsigned PKT_LEN   = DefPktLen,
  parameter int unsigned EDGE_MODE = 1,
  parameter int unsigned OVF_W     = DefOvfW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_data_valid,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_flush,
  input  logic                          i_clear_overflow,
  output logic [DATA_W-1:0]             o_src_data,
  output logic                          o_src_valid,
  input  logic                          i_src_ready,
  output logic                          o_src_startofpacket,
  output logic                          o_src_endofpacket,
  output logic [clog2_plus1(DEPTH)-1:0] o_fill_level,
  output logic                          o_overflow,
  output logic [OVF_W-1:0]              o_overflow_count
);

  localparam int unsigned      IdxW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(PKT_LEN - 1);

  logic              r_data_valid_d;
  logic [IdxW-1:0]   r_idx;
  logic              r_overflow;
  logic [OVF_W-1:0]  r_ovf_count;
  logic              w_cap;
  logic              w_pop;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  frame_flags_t      w_flags;

  // Edge mode captures once per rising edge of data_valid; level mode every cycle.
  assign w_cap = (EDGE_MODE != 0) ? (i_data_valid & ~r_data_valid_d) : i_data_valid;

  assign o_src_valid = ~w_empty;
  assign w_pop       = o_src_valid & i_src_ready;
  assign w_drop      = w_cap & w_full & ~w_pop;

  msgdma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_cap),
    .i_pop   (w_pop),
    .i_flush (i_flush),
    .i_data  (i_data),
    .o_data  (o_src_data),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_level (o_fill_level)
  );

  // Delayed data_valid for edge detection; keeps tracking through flush so an
  // edge seen during flush is consumed rather than deferred.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data_valid_d <= 1'b0;
    end else begin
      r_data_valid_d <= i_data_valid;
    end
  end

  // Word-within-packet index; advances on each accepted word, restarts on flush.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_idx <= '0;
    end else if (w_pop) begin
      r_idx <= (r_idx == LastIdx) ? '0 : r_idx + IdxW'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter; clear beats a same-cycle drop.
  always_ff @(posedge clk) begin
    if (!reset_n || i_clear_overflow) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_ovf_count != '1) begin
        r_ovf_count <= r_ovf_count + OVF_W'(1);
      end
    end
  end

  // Framing flags follow the head word, so they hold while the sink stalls.
  always_comb begin
    w_flags     = '0;
    w_flags.sop = o_src_valid & (r_idx == '0);
    w_flags.eop = o_src_valid & (r_idx == LastIdx);
  end

  assign o_src_startofpacket = w_flags.sop;
  assign o_src_endofpacket   = w_flags.eop;
  assign o_overflow          = r_overflow;
  assign o_overflow_count    = r_ovf_count;

endmodule

// File: tb/tb_msgdma_stream_source.sv
// Directed self-checking bench for msgdma_stream_source using three configurations.
module tb_msgdma_stream_source;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  // Instance A: edge capture, 4-word packets.
  logic        a_dv, a_flush, a_clr, a_ready;
  logic [31:0] a_data, a_sdata;
  logic        a_valid, a_sop, a_eop, a_ovf;
  logic [4:0]  a_lvl;
  logic [15:0] a_ovfc;

  // Instance B: level capture, 3-word packets.
  logic        b_dv, b_flush, b_clr, b_ready;
  logic [31:0] b_data, b_sdata;
  logic        b_valid, b_sop, b_eop, b_ovf;
  logic [4:0]  b_lvl;
  logic [15:0] b_ovfc;

  // Instance C: tiny FIFO, single-word packets, 2-bit drop counter.
  logic        c_dv, c_flush, c_clr, c_ready;
  logic [31:0] c_data, c_sdata;
  logic        c_valid, c_sop, c_eop, c_ovf;
  logic [1:0]  c_lvl;
  logic [1:0]  c_ovfc;

  msgdma_stream_source #(
    .DATA_W(32), .DEPTH(16), .PKT_LEN(4), .EDGE_MODE(1), .OVF_W(16)
  ) u_dut_a (
    .clk(clk), .reset_n(reset_n), .i_data_valid(a_dv), .i_data(a_data),
    .i_flush(a_flush), .i_clear_overflow(a_clr), .o_src_data(a_sdata),
    .o_src_valid(a_valid), .i_src_ready(a_ready), .o_src_startofpacket(a_sop),
    .o_src_endofpacket(a_eop), .o_fill_level(a_lvl), .o_overflow(a_ovf),
    .o_overflow_count(a_ovfc)
  );

  msgdma_stream_source #(
    .DATA_W(32), .DEPTH(16), .PKT_LEN(3), .EDGE_MODE(0), .OVF_W(16)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .i_data_valid(b_dv), .i_data(b_data),
    .i_flush(b_flush), .i_clear_overflow(b_clr), .o_src_data(b_sdata),
    .o_src_valid(b_valid), .i_src_ready(b_ready), .o_src_startofpacket(b_sop),
    .o_src_endofpacket(b_eop), .o_fill_level(b_lvl), .o_overflow(b_ovf),
    .o_overflow_count(b_ovfc)
  );

  msgdma_stream_source #(
    .DATA_W(32), .DEPTH(2), .PKT_LEN(1), .EDGE_MODE(0), .OVF_W(2)
  ) u_dut_c (
    .clk(clk), .reset_n(reset_n), .i_data_valid(c_dv), .i_data(c_data),
    .i_flush(c_flush), .i_clear_overflow(c_clr), .o_src_data(c_sdata),
    .o_src_valid(c_valid), .i_src_ready(c_ready), .o_src_startofpacket(c_sop),
    .o_src_endofpacket(c_eop), .o_fill_level(c_lvl), .o_overflow(c_ovf),
    .o_overflow_count(c_ovfc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int j;
    reset_n = 1'b0;
    {a_dv, a_flush, a_clr, a_ready, a_data} = '0;
    {b_dv, b_flush, b_clr, b_ready, b_data} = '0;
    {c_dv, c_flush, c_clr, c_ready, c_data} = '0;
    tick();
    tick();

    // Reset state
    check("rst_valid", a_valid, 0);
    check("rst_sop",   a_sop,   0);
    check("rst_eop",   a_eop,   0);
    check("rst_level", a_lvl,   0);
    check("rst_data",  a_sdata, 0);
    check("rst_ovf",   a_ovf,   0);
    check("rst_ovfc",  a_ovfc,  0);
    reset_n = 1'b1;
    tick();

    // 1: four edge-captured words, one packet, drained immediately
    a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_dv   = 1'b1;
      a_data = 32'h11 * (i + 1);
      tick();
      check("t1_valid", a_valid, 1);
      check("t1_data",  a_sdata, 32'h11 * (i + 1));
      check("t1_sop",   a_sop,   (i == 0) ? 1 : 0);
      check("t1_eop",   a_eop,   (i == 3) ? 1 : 0);
      a_dv = 1'b0;
      tick();
    end
    check("t1_level", a_lvl, 0);
    check("t1_valid_end", a_valid, 0);

    // 2a: held data_valid in edge mode captures a single word
    a_ready = 1'b0;
    a_dv    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_data = 32'h100 + k;
      tick();
    end
    a_dv = 1'b0;
    check("t2a_level", a_lvl, 1);
    check("t2a_data",  a_sdata, 32'h100);
    a_ready = 1'b1;
    tick();
    check("t2a_drain", a_lvl, 0);
    a_ready = 1'b0;

    // 2b: held data_valid in level mode captures every cycle
    b_dv = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b_data = 32'h200 + k;
      tick();
    end
    check("t2b_level", b_lvl, 10);
    check("t2b_data",  b_sdata, 32'h200);
    check("t2b_sop",   b_sop, 1);

    // 3: ten more captures overflow the 16-deep FIFO by four
    for (int k = 10; k < 20; k++) begin
      b_data = 32'h200 + k;
      tick();
    end
    b_dv = 1'b0;
    check("t3_level", b_lvl, 16);
    check("t3_ovf",   b_ovf, 1);
    check("t3_ovfc",  b_ovfc, 4);
    check("t3_head",  b_sdata, 32'h200);

    // 4: full FIFO with simultaneous pop and capture keeps level, no drop
    b_ready = 1'b1;
    b_dv    = 1'b1;
    b_data  = 32'h3AA;
    tick();
    b_dv = 1'b0;
    check("t4_level", b_lvl, 16);
    check("t4_ovfc",  b_ovfc, 4);
    check("t4_head",  b_sdata, 32'h201);
    for (int k = 0; k < 16; k++) begin
      check("t4_drain", b_sdata, (k < 15) ? 32'h201 + k : 32'h3AA);
      tick();
    end
    check("t4_empty", b_lvl, 0);
    b_ready = 1'b0;

    // 5: two 3-word packets under alternating backpressure
    b_flush = 1'b1;
    tick();
    b_flush = 1'b0;
    b_dv    = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_data = 32'h500 + k;
      tick();
    end
    b_dv = 1'b0;
    j = 0;
    for (int cyc = 0; cyc < 30 && j < 6; cyc++) begin
      logic take;
      if (b_valid) begin
        check("t5_data", b_sdata, 32'h500 + j);
        check("t5_sop",  b_sop, (j % 3 == 0) ? 1 : 0);
        check("t5_eop",  b_eop, (j % 3 == 2) ? 1 : 0);
      end
      b_ready = cyc[0];
      take    = b_valid & b_ready;
      tick();
      if (take) j++;
    end
    b_ready = 1'b0;
    check("t5_count", j, 6);
    check("t5_level", b_lvl, 0);

    // 6: flush mid-packet, then the next word starts a fresh packet
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_dv   = 1'b1;
      a_data = 32'h600 + k;
      tick();
      a_dv = 1'b0;
      tick();
    end
    check("t6_level5", a_lvl, 5);
    a_ready = 1'b1;
    tick();
    tick();
    a_ready = 1'b0;
    check("t6_level3", a_lvl, 3);
    check("t6_head",   a_sdata, 32'h602);
    check("t6_midsop", a_sop, 0);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("t6_fl_valid", a_valid, 0);
    check("t6_fl_level", a_lvl, 0);
    a_dv   = 1'b1;
    a_data = 32'h6AA;
    tick();
    a_dv = 1'b0;
    check("t6_new_data", a_sdata, 32'h6AA);
    check("t6_new_sop",  a_sop, 1);
    check("t6_new_eop",  a_eop, 0);
    a_flush = 1'b1;
    tick();
    // Edge arriving during flush is lost, not deferred
    a_dv = 1'b1;
    tick();
    a_flush = 1'b0;
    tick();
    a_dv = 1'b0;
    check("t6_lost_edge", a_lvl, 0);

    // 6b: clear_overflow coincident with a drop
    b_dv = 1'b1;
    for (int k = 0; k < 17; k++) begin
      b_data = 32'h800 + k;
      tick();
    end
    check("t6b_ovfc5", b_ovfc, 5);
    b_clr = 1'b1;
    tick();
    b_clr = 1'b0;
    check("t6b_clr_cnt", b_ovfc, 0);
    check("t6b_clr_ovf", b_ovf, 0);
    tick();
    b_dv = 1'b0;
    check("t6b_recount", b_ovfc, 1);
    check("t6b_reovf",   b_ovf, 1);

    // Saturating counter and single-word packets
    c_dv = 1'b1;
    for (int k = 0; k < 7; k++) begin
      c_data = 32'h700 + k;
      tick();
    end
    c_dv = 1'b0;
    check("c_sat",   c_ovfc, 3);
    check("c_ovf",   c_ovf, 1);
    check("c_level", c_lvl, 2);
    c_ready = 1'b1;
    check("c_w0_data", c_sdata, 32'h700);
    check("c_w0_sop",  c_sop, 1);
    check("c_w0_eop",  c_eop, 1);
    tick();
    check("c_w1_data", c_sdata, 32'h701);
    check("c_w1_sop",  c_sop, 1);
    check("c_w1_eop",  c_eop, 1);
    tick();
    check("c_empty", c_lvl, 0);
    check("c_sop_idle", c_sop, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
